// File: rtl/shift_capture_hex.sv
// Serial shift register with capture copy, shown one nibble at a time on a
// registered seven-segment output. Pin strobes are synchronized and edge-detected.
module shift_capture_hex #(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int NIB   = DEPTH / 4;
    localparam int PTR_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NIB - 1);

    logic clk;
    logic rst;
    assign clk = io_in[0];
    assign rst = io_in[1];

    logic [5:0]       sync_p [SYNC_STAGES];
    logic [5:0]       sync_last;
    logic [2:0]       hist_p0;
    logic             shf_pls, cap_pls, stp_pls;
    logic [DEPTH-1:0] sr, cap;
    logic [PTR_W-1:0] ptr;
    logic             cv;
    logic [DEPTH-1:0] src;
    logic [3:0]       nib, nib_d;
    logic [6:0]       seg_d, seg_p1;
    logic             cv_p1;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Stage: synchronizer chain, data and strobes kept aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
            hist_p0 <= '0;
        end else begin
            sync_p[0] <= io_in[7:2];
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
            hist_p0 <= sync_last[3:1];
        end
    end

    assign sync_last = sync_p[SYNC_STAGES-1];
    assign shf_pls   = sync_last[1] & ~hist_p0[0];
    assign cap_pls   = sync_last[2] & ~hist_p0[1];
    assign stp_pls   = sync_last[3] & ~hist_p0[2];

    // Stage: shift register, capture copy and nibble pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cap <= '0;
            cv  <= 1'b0;
            ptr <= '0;
        end else begin
            if (shf_pls) sr <= {sr[DEPTH-2:0], sync_last[0]};
            if (cap_pls) begin
                cap <= sr;
                cv  <= 1'b1;
            end
            if (stp_pls) ptr <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
        end
    end

    always_comb begin
        src = sync_last[4] ? cap : sr;
        nib = '0;
        for (int k = 0; k < NIB; k++)
            if (ptr == PTR_W'(k)) nib = src[4*k +: 4];
        nib_d = sync_last[5] ? {nib[0], nib[1], nib[2], nib[3]} : nib;
        seg_d = (sync_last[4] && !cv) ? 7'h40 : hex7(nib_d);
    end

    // Stage: registered display; reset shows hex 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_p1 <= 7'h3F;
            cv_p1  <= 1'b0;
        end else begin
            seg_p1 <= seg_d;
            cv_p1  <= cv;
        end
    end

    assign io_out = {cv_p1, seg_p1};

endmodule

// File: tb/tb_shift_capture_hex.sv
// Directed bench for shift_capture_hex: hex display, reverse, nibble stepping,
// capture, same-cycle shift/capture, held strobes, resets and pipeline latency.
module tb_shift_capture_hex;

    logic clk = 1'b0, rst = 1'b0, din = 1'b0, shf = 1'b0, capt = 1'b0;
    logic stp = 1'b0, view = 1'b0, rev = 1'b0;
    logic [7:0] io_in, io_out, io_out4;
    int n_cmp = 0;
    int n_bad = 0;

    assign io_in = {rev, view, stp, capt, shf, din, rst, clk};

    shift_capture_hex #(.DEPTH(8), .SYNC_STAGES(2)) u_dut  (.io_in(io_in), .io_out(io_out));
    shift_capture_hex #(.DEPTH(4), .SYNC_STAGES(2)) u_dut4 (.io_in(io_in), .io_out(io_out4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        din = b; shf = 1'b1; cyc(4);
        shf = 1'b0; cyc(4);
    endtask

    task automatic cap_pulse();
        capt = 1'b1; cyc(4);
        capt = 1'b0; cyc(4);
    endtask

    task automatic step_pulse();
        stp = 1'b1; cyc(4);
        stp = 1'b0; cyc(4);
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(2);
        rst = 1'b0; cyc(2);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk("rst_async", io_out, 8'h3F);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        chk("post_rst", io_out, 8'h3F);

        // 1,0,1,0 -> sr = 0x0A
        shift_bit(1); shift_bit(0); shift_bit(1); shift_bit(0);
        chk("hex_A", io_out, 8'h77);
        chk("d4_hex_A", io_out4, 8'h77);
        rev = 1'b1; cyc(4);
        chk("rev_5", io_out, 8'h6D);
        rev = 1'b0; cyc(4);

        // 0,0,0,1 -> sr = 0xA1
        shift_bit(0); shift_bit(0); shift_bit(0); shift_bit(1);
        chk("sr_A1_p0", io_out, 8'h06);
        step_pulse();
        chk("step_p1", io_out, 8'h77);
        chk("d4_step", io_out4, 8'h06);
        step_pulse();
        chk("wrap_p0", io_out, 8'h06);
        chk("d4_wrap", io_out4, 8'h06);

        // view change reaches the pins after SYNC_STAGES+1 clocks
        view = 1'b1;
        cyc(2); chk("view_lat_old", io_out, 8'h06);
        cyc(1); chk("view_lat_new", io_out, 8'h40);
        view = 1'b0; cyc(4);

        do_reset();
        view = 1'b1; cyc(4);
        chk("dash", io_out, 8'h40);
        shift_bit(1); shift_bit(1);
        chk("dash_hold", io_out, 8'h40);
        cap_pulse();
        chk("cap_03", io_out, 8'hCF);
        view = 1'b0; cyc(4);
        chk("live_03", io_out, 8'hCF);

        // strobe reaches the pins after SYNC_STAGES+2 clocks: sr 0x03 -> 0x06
        din = 1'b0; shf = 1'b1;
        cyc(3); chk("shf_lat_old", io_out, 8'hCF);
        cyc(1); chk("shf_lat_new", io_out, 8'hFD);
        shf = 1'b0; cyc(4);

        // shift and capture together: cap gets pre-shift sr
        do_reset();
        shift_bit(1);
        din = 1'b1; shf = 1'b1; capt = 1'b1; cyc(4);
        shf = 1'b0; capt = 1'b0; cyc(4);
        view = 1'b1; cyc(4);
        chk("same_cap", io_out, 8'h86);
        view = 1'b0; cyc(4);
        chk("same_sr", io_out, 8'hCF);

        // held strobe acts once
        do_reset();
        din = 1'b1; shf = 1'b1; cyc(20);
        shf = 1'b0; cyc(4);
        chk("hold_one", io_out, 8'h06);

        // reset while a pulse is still in the synchronizer
        shf = 1'b1; cyc(1);
        rst = 1'b1;
        #1 chk("rst_mid_async", io_out, 8'h3F);
        shf = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(6);
        chk("rst_mid_none", io_out, 8'h3F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
